// File: rtl/sr_sipo_deframer_pkg.sv
// Shared definitions for the serial deframer and its upstream PISO stage.
package sr_sipo_deframer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 4;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry output buffer with valid/ready handshake and sticky overrun flag.
module sipo_hold_reg
   import sr_sipo_deframer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   input  logic             ovr_clr_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             ovr_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             drain, accept, drop;

   always_comb begin
      drain  = valid_q & ready_i;
      accept = load_i & (~valid_q | drain);
      drop   = load_i & ~accept;

      data_d  = data_q;
      valid_d = valid_q;
      if (accept) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      ovr_d = ovr_q;
      if (drop) begin
         ovr_d = 1'b1;
      end else if (ovr_clr_i) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ovr_o   = ovr_q;

endmodule

// File: rtl/sr_sipo_deframer.sv
// Serial-in parallel-out deframer: aligns on frame_start, assembles WIDTH-bit words.
module sr_sipo_deframer
   import sr_sipo_deframer_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          CONTINUOUS = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           serial_in,
   input  logic                           serial_en,
   input  logic                           frame_start,
   output logic [WIDTH-1:0]               data_out,
   output logic                           data_valid,
   input  logic                           data_ready,
   output logic                           overrun,
   input  logic                           overrun_clr,
   output logic                           frame_err,
   output logic [cnt_width(WIDTH)-1:0]    bit_count
);

   localparam int unsigned    CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ferr_q, ferr_d;
   logic             word_done;
   logic [WIDTH-1:0] word;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
      if (MSB_FIRST) return {cur[WIDTH-2:0], b};
      else           return {b, cur[WIDTH-1:1]};
   endfunction

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      ferr_d    = 1'b0;
      word_done = 1'b0;
      word      = shift_in(shreg_q, serial_in);

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d = ST_SHIFT;
               shreg_d = serial_en ? shift_in('0, serial_in) : '0;
               cnt_d   = serial_en ? ONE_CNT : '0;
            end
         end
         ST_SHIFT: begin
            // Completion takes priority over resync; a coincident frame_start
            // keeps us framed so the following bit opens the next word.
            if (serial_en && cnt_q == LAST_CNT) begin
               word_done = 1'b1;
               shreg_d   = '0;
               cnt_d     = '0;
               state_d   = (CONTINUOUS || frame_start) ? ST_SHIFT : ST_IDLE;
            end else if (frame_start) begin
               ferr_d  = (cnt_q != '0);
               shreg_d = serial_en ? shift_in('0, serial_in) : '0;
               cnt_d   = serial_en ? ONE_CNT : '0;
            end else if (serial_en) begin
               shreg_d = word;
               cnt_d   = cnt_q + ONE_CNT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bit_count = cnt_q;
   assign frame_err = ferr_q;

   sipo_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load_i    (word_done),
      .data_i    (word),
      .ready_i   (data_ready),
      .ovr_clr_i (overrun_clr),
      .data_o    (data_out),
      .valid_o   (data_valid),
      .ovr_o     (overrun)
   );

endmodule

// File: tb/tb_sr_sipo_deframer.sv
// Directed bench: MSB-first continuous and LSB-first single-shot deframers on shared stimulus.
module tb_sr_sipo_deframer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       serial_in = 1'b0;
   logic       serial_en = 1'b0;
   logic       frame_start = 1'b0;
   logic       data_ready = 1'b0;
   logic       overrun_clr = 1'b0;

   logic [3:0] m_data, l_data;
   logic       m_valid, l_valid, m_ovr, l_ovr, m_ferr, l_ferr;
   logic [2:0] m_cnt, l_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   sr_sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) u_msb (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_en(serial_en),
      .frame_start(frame_start), .data_out(m_data), .data_valid(m_valid),
      .data_ready(data_ready), .overrun(m_ovr), .overrun_clr(overrun_clr),
      .frame_err(m_ferr), .bit_count(m_cnt)
   );

   sr_sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_en(serial_en),
      .frame_start(frame_start), .data_out(l_data), .data_valid(l_valid),
      .data_ready(data_ready), .overrun(l_ovr), .overrun_clr(overrun_clr),
      .frame_err(l_ferr), .bit_count(l_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic fs, input logic en, input logic b);
      frame_start = fs;
      serial_en   = en;
      serial_in   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #3;
      chk("rst_data",  16'(m_data),  16'h0);
      chk("rst_valid", 16'(m_valid), 16'h0);
      chk("rst_cnt",   16'(m_cnt),   16'h0);
      chk("rst_ovr",   16'(m_ovr),   16'h0);
      chk("rst_ferr",  16'(m_ferr),  16'h0);
      @(negedge clk);
      reset = 1'b1;

      // basic word, both bit orders
      data_ready = 1'b1;
      step(1, 1, 1); chk("t1_cnt1", 16'(m_cnt), 16'h1);
      chk("t1_valid_early", 16'(m_valid), 16'h0);
      step(0, 1, 0); chk("t1_cnt2", 16'(m_cnt), 16'h2);
      step(0, 1, 1); chk("t1_cnt3", 16'(m_cnt), 16'h3);
      chk("t1_valid_pre", 16'(m_valid), 16'h0);
      step(0, 1, 1);
      chk("t1_m_data",  16'(m_data),  16'hB);
      chk("t1_m_valid", 16'(m_valid), 16'h1);
      chk("t1_m_cnt0",  16'(m_cnt),   16'h0);
      chk("t2_l_data",  16'(l_data),  16'hD);
      chk("t2_l_valid", 16'(l_valid), 16'h1);
      idle(1);
      chk("t1_m_valid_drop", 16'(m_valid), 16'h0);
      chk("t2_l_valid_drop", 16'(l_valid), 16'h0);

      // overrun with consumer stalled
      data_ready = 1'b0;
      step(1, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      chk("t3_data1",  16'(m_data),  16'hB);
      chk("t3_valid1", 16'(m_valid), 16'h1);
      chk("t3_ovr0",   16'(m_ovr),   16'h0);
      step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      chk("t3_ovr_pre", 16'(m_ovr), 16'h0);
      step(0, 1, 0);
      chk("t3_ovr1",     16'(m_ovr),   16'h1);
      chk("t3_data_hold", 16'(m_data), 16'hB);
      chk("t3_valid_hold", 16'(m_valid), 16'h1);
      chk("t3_l_ovr",    16'(l_ovr),   16'h0);
      chk("t3_l_cnt",    16'(l_cnt),   16'h0);
      chk("t3_l_data",   16'(l_data),  16'hD);
      idle(2);
      chk("t3_ovr_sticky", 16'(m_ovr), 16'h1);
      overrun_clr = 1'b1;
      idle(1);
      overrun_clr = 1'b0;
      chk("t3_ovr_clr", 16'(m_ovr), 16'h0);
      data_ready = 1'b1;
      idle(1);
      chk("t3_drain", 16'(m_valid), 16'h0);

      // resync discards partial word
      step(1, 1, 1); step(0, 1, 1);
      chk("t4_cnt2", 16'(m_cnt), 16'h2);
      step(1, 1, 0);
      chk("t4_ferr",   16'(m_ferr), 16'h1);
      chk("t4_l_ferr", 16'(l_ferr), 16'h1);
      chk("t4_cnt1",   16'(m_cnt),  16'h1);
      step(0, 1, 0);
      chk("t4_ferr_pulse", 16'(m_ferr), 16'h0);
      step(0, 1, 1); step(0, 1, 0);
      chk("t4_m_data",  16'(m_data),  16'h2);
      chk("t4_m_valid", 16'(m_valid), 16'h1);
      chk("t4_l_data",  16'(l_data),  16'h4);
      chk("t4_ferr_end", 16'(m_ferr), 16'h0);

      // idle gaps inside a word
      step(1, 1, 1); chk("t5_cnt1", 16'(m_cnt), 16'h1);
      idle(3);       chk("t5_gap1", 16'(m_cnt), 16'h1);
      step(0, 1, 0); chk("t5_cnt2", 16'(m_cnt), 16'h2);
      idle(3);       chk("t5_gap2", 16'(m_cnt), 16'h2);
      step(0, 1, 0); chk("t5_cnt3", 16'(m_cnt), 16'h3);
      idle(3);       chk("t5_valid_gap", 16'(m_valid), 16'h0);
      step(0, 1, 1);
      chk("t5_m_data", 16'(m_data), 16'h9);
      chk("t5_l_data", 16'(l_data), 16'h9);
      chk("t5_cnt0",   16'(m_cnt),  16'h0);

      // frame_start on the last bit completes normally
      step(1, 1, 1); step(0, 1, 1); step(0, 1, 0); step(1, 1, 1);
      chk("t5b_m_data", 16'(m_data), 16'hD);
      chk("t5b_l_data", 16'(l_data), 16'hB);
      chk("t5b_ferr",   16'(m_ferr), 16'h0);
      chk("t5b_cnt",    16'(m_cnt),  16'h0);
      idle(1);
      chk("t5b_ferr2",  16'(m_ferr), 16'h0);

      // asynchronous reset mid-word with a held word
      data_ready = 1'b0;
      step(1, 1, 1); step(0, 1, 1); step(0, 1, 0); step(0, 1, 0);
      chk("t6_held", 16'(m_data), 16'hC);
      step(0, 1, 1); step(0, 1, 0);
      chk("t6_cnt2",  16'(m_cnt),   16'h2);
      chk("t6_valid", 16'(m_valid), 16'h1);
      serial_en = 1'b0;
      reset = 1'b0;
      #1;
      chk("t6_rst_data",  16'(m_data),  16'h0);
      chk("t6_rst_valid", 16'(m_valid), 16'h0);
      chk("t6_rst_cnt",   16'(m_cnt),   16'h0);
      chk("t6_rst_l_valid", 16'(l_valid), 16'h0);
      @(negedge clk);
      reset = 1'b1;
      data_ready = 1'b1;
      step(1, 1, 0); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
      chk("t6_m_data",  16'(m_data),  16'h7);
      chk("t6_m_valid", 16'(m_valid), 16'h1);
      chk("t6_l_data",  16'(l_data),  16'hE);
      chk("t6_l_valid", 16'(l_valid), 16'h1);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
